// File: rtl/n_one_mux_pipe.sv
// n_one_mux_pipe
//   Parametrised N:1 datapath mux followed by a STAGES-deep register pipeline
//   with valid tracking. Used as the registered operand/forwarding select at
//   CPU pipeline boundaries (ID/EX, EX/MEM). Supports stall (hold), flush
//   (bubble insert) and a sticky out-of-range-select error flag.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_bus    N_IN packed inputs, input i = in_bus[i*WIDTH +: WIDTH]
//   select    binary index of the input to pass
//   in_valid  current input/select is a real instruction slot
//   stall     hold the entire pipe, input ignored
//   flush     kill all in-flight entries (wins over stall)
//   err_clr   clear sel_err (a simultaneous new error still sets it)
//   m_out     data from the last stage
//   out_valid last stage holds a valid entry
//   sel_err   sticky: a valid input arrived with select >= N_IN
module n_one_mux_pipe #(
  parameter int               WIDTH   = 32,
  parameter int               N_IN    = 4,
  parameter int               SEL_W   = 2,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      select,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      m_out,
  output logic                  out_valid,
  output logic                  sel_err
);

  logic [WIDTH-1:0] mux_data;
  logic             sel_bad;
  logic             advance;

  logic [WIDTH-1:0] data_q [STAGES];
  logic [WIDTH-1:0] data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic             sel_err_q;
  logic             sel_err_d;

  // Stage-0 select. An index that matches no input falls through to RST_VAL
  // and flags sel_bad, which avoids a separate range comparison that would
  // need care when N_IN does not fit in SEL_W bits.
  always_comb begin
    mux_data = RST_VAL;
    sel_bad  = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (32'(select) == 32'(i)) begin
        mux_data = in_bus[i*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  // The pipe only moves on an edge that is neither flushed nor stalled.
  assign advance = !flush && !stall;

  // Next-state for the data/valid pipe: flush clears everything even while
  // stalled, a stall holds everything, otherwise every stage shifts by one.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        data_d[k] = RST_VAL;
      end
      valid_d = '0;
    end else if (advance) begin
      data_d[0]  = mux_data;
      valid_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // Sticky error: clear first so that a new bad select on the same edge wins.
  always_comb begin
    sel_err_d = sel_err_q;
    if (err_clr) begin
      sel_err_d = 1'b0;
    end
    if (advance && in_valid && sel_bad) begin
      sel_err_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= RST_VAL;
      end
      valid_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Outputs come straight from flops, so no input reaches them combinationally.
  assign m_out     = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_n_one_mux_pipe.sv
// tb_n_one_mux_pipe
//   Directed testbench for n_one_mux_pipe. Instances:
//     u_main  WIDTH=32 N_IN=4 STAGES=2 (reset, latency, stall, flush)
//     u_bad   WIDTH=32 N_IN=3 STAGES=1 RST_VAL=DEADBEEF (bad select / sel_err)
//     g_sweep WIDTH=8 N_IN=16 and N_IN=2, STAGES=1..4 (latency/stream sweep)
//   Control inputs are shared; each test only looks at the instance it targets.
module tb_n_one_mux_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, stall, flush, err_clr;

  logic [127:0] main_bus;
  logic [1:0]   main_sel;
  logic [31:0]  main_out;
  logic         main_v, main_err;

  logic [95:0]  bad_bus;
  logic [1:0]   bad_sel;
  logic [31:0]  bad_out;
  logic         bad_v, bad_err;

  logic [127:0] sw_bus;
  logic [3:0]   sw_sel;
  logic [7:0]   sw16_out [1:4];
  logic         sw16_v   [1:4];
  logic         sw16_err [1:4];
  logic [7:0]   sw2_out  [1:4];
  logic         sw2_v    [1:4];
  logic         sw2_err  [1:4];

  int n_checks = 0;
  int n_fail   = 0;

  n_one_mux_pipe #(.WIDTH(32), .N_IN(4), .SEL_W(2), .STAGES(2), .RST_VAL(32'h0)) u_main (
    .clk(clk), .rst(rst), .in_bus(main_bus), .select(main_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .m_out(main_out), .out_valid(main_v), .sel_err(main_err)
  );

  n_one_mux_pipe #(.WIDTH(32), .N_IN(3), .SEL_W(2), .STAGES(1), .RST_VAL(32'hDEAD_BEEF)) u_bad (
    .clk(clk), .rst(rst), .in_bus(bad_bus), .select(bad_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .m_out(bad_out), .out_valid(bad_v), .sel_err(bad_err)
  );

  // One 16-input and one 2-input pipe for every legal depth.
  for (genvar s = 1; s <= 4; s++) begin : g_sweep
    n_one_mux_pipe #(.WIDTH(8), .N_IN(16), .SEL_W(4), .STAGES(s), .RST_VAL(8'h00)) u16 (
      .clk(clk), .rst(rst), .in_bus(sw_bus), .select(sw_sel), .in_valid(in_valid),
      .stall(stall), .flush(flush), .err_clr(err_clr),
      .m_out(sw16_out[s]), .out_valid(sw16_v[s]), .sel_err(sw16_err[s])
    );
    n_one_mux_pipe #(.WIDTH(8), .N_IN(2), .SEL_W(1), .STAGES(s), .RST_VAL(8'h00)) u2 (
      .clk(clk), .rst(rst), .in_bus(sw_bus[15:0]), .select(sw_sel[0:0]), .in_valid(in_valid),
      .stall(stall), .flush(flush), .err_clr(err_clr),
      .m_out(sw2_out[s]), .out_valid(sw2_v[s]), .sel_err(sw2_err[s])
    );
  end

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    main_sel = 2'd0;
    bad_sel  = 2'd0;
    sw_sel   = 4'd0;
    main_bus = {32'h33, 32'h22, 32'h11, 32'h00};
    bad_bus  = {32'h22, 32'h11, 32'h00};
    sw_bus   = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reset held for two cycles clears every output of both main instances.
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (main_out !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_m_out: got %h expected %h", main_out, 32'h0);
    end
    n_checks++;
    if (main_v !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", main_v);
    end
    n_checks++;
    if (main_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_sel_err: got %b expected 0", main_err);
    end
    n_checks++;
    if (bad_out !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL reset_rst_val: got %h expected %h", bad_out, 32'hDEAD_BEEF);
    end
    rst = 1'b0;
  endtask

  // Two-stage latency and a full select sweep; input i carries 0x11*i.
  task automatic test_latency();
    int sels [5] = '{2, 0, 1, 2, 3};
    logic exp_v;
    logic [31:0] exp_d;
    pulse_reset();
    for (int e = 0; e < 7; e++) begin
      if (e < 5) begin
        main_sel = 2'(sels[e]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      exp_v = (e >= 1) && (e <= 5);
      n_checks++;
      if (main_v !== exp_v) begin
        n_fail++; $display("[TB] FAIL latency_valid[%0d]: got %b expected %b", e, main_v, exp_v);
      end
      if (exp_v) begin
        exp_d = 32'(17 * sels[e-1]);
        n_checks++;
        if (main_out !== exp_d) begin
          n_fail++; $display("[TB] FAIL latency_data[%0d]: got %h expected %h", e, main_out, exp_d);
        end
      end
    end
  endtask

  // Stall for three edges with toggling inputs; output frozen, then stream resumes.
  task automatic test_stall();
    logic [1:0] stall_sels [3] = '{2'd3, 2'd0, 2'd3};
    pulse_reset();
    in_valid = 1'b1;
    main_sel = 2'd1;
    tick();
    main_sel = 2'd2;
    tick();
    n_checks++;
    if (main_out !== 32'h11 || main_v !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_pre: got %h/%b expected 00000011/1", main_out, main_v);
    end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      main_sel = stall_sels[c];
      main_bus = ~main_bus;
      tick();
      n_checks++;
      if (main_out !== 32'h11) begin
        n_fail++; $display("[TB] FAIL stall_hold_data[%0d]: got %h expected %h", c, main_out, 32'h11);
      end
      n_checks++;
      if (main_v !== 1'b1) begin
        n_fail++; $display("[TB] FAIL stall_hold_valid[%0d]: got %b expected 1", c, main_v);
      end
    end
    stall    = 1'b0;
    main_bus = {32'h33, 32'h22, 32'h11, 32'h00};
    main_sel = 2'd3;
    tick();
    n_checks++;
    if (main_out !== 32'h22 || main_v !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_resume1: got %h/%b expected 00000022/1", main_out, main_v);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (main_out !== 32'h33 || main_v !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_resume2: got %h/%b expected 00000033/1", main_out, main_v);
    end
    tick();
    n_checks++;
    if (main_v !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_drain: got %b expected 0", main_v);
    end
  endtask

  // Flush with stall high and two entries in flight; the flush-edge input is dropped.
  task automatic test_flush();
    pulse_reset();
    in_valid = 1'b1;
    main_sel = 2'd1;
    tick();
    main_sel = 2'd2;
    tick();
    stall    = 1'b1;
    flush    = 1'b1;
    main_sel = 2'd3;
    tick();
    n_checks++;
    if (main_v !== 1'b0) begin
      n_fail++; $display("[TB] FAIL flush_valid: got %b expected 0", main_v);
    end
    n_checks++;
    if (main_out !== 32'h0) begin
      n_fail++; $display("[TB] FAIL flush_data: got %h expected %h", main_out, 32'h0);
    end
    stall    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (main_v !== 1'b0) begin
        n_fail++; $display("[TB] FAIL flush_after_valid[%0d]: got %b expected 0", c, main_v);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        v, clr, stl, fl, rs;
    logic [31:0] eo;
    logic        ev, ee;
  } bad_vec_t;

  // N_IN=3 with select=3: RST_VAL data, sticky error, clear/set priority,
  // no set on invalid, stalled or flushed edges.
  task automatic test_bad_select();
    bad_vec_t vecs [11] = '{
      '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11,        1'b1, 1'b0},
      '{2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1},
      '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00,        1'b1, 1'b1},
      '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22,        1'b1, 1'b1},
      '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00,        1'b1, 1'b0},
      '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0},
      '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0},
      '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0},
      '{2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1},
      '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11,        1'b1, 1'b1},
      '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}
    };
    pulse_reset();
    for (int i = 0; i < 11; i++) begin
      bad_sel  = vecs[i].sel;
      in_valid = vecs[i].v;
      err_clr  = vecs[i].clr;
      stall    = vecs[i].stl;
      flush    = vecs[i].fl;
      rst      = vecs[i].rs;
      tick();
      n_checks++;
      if (bad_out !== vecs[i].eo) begin
        n_fail++; $display("[TB] FAIL bad_data[%0d]: got %h expected %h", i, bad_out, vecs[i].eo);
      end
      n_checks++;
      if (bad_v !== vecs[i].ev) begin
        n_fail++; $display("[TB] FAIL bad_valid[%0d]: got %b expected %b", i, bad_v, vecs[i].ev);
      end
      n_checks++;
      if (bad_err !== vecs[i].ee) begin
        n_fail++; $display("[TB] FAIL bad_sel_err[%0d]: got %b expected %b", i, bad_err, vecs[i].ee);
      end
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  // Depth 1..4 with N_IN=16 and 2: after edge e a depth-s pipe shows the
  // input sampled on edge e-(s-1), or reset contents before that.
  task automatic test_param_sweep();
    logic [7:0] h16 [20];
    logic [7:0] h2  [20];
    logic       hv  [20];
    logic [7:0] e16, e2;
    logic       ev;
    pulse_reset();
    for (int e = 0; e < 20; e++) begin
      for (int b = 0; b < 16; b++) begin
        sw_bus[b*8 +: 8] = 8'(b * 17) ^ 8'(e * 5);
      end
      sw_sel   = 4'((e * 7 + 3) % 16);
      in_valid = (e % 3) != 1;
      h16[e]   = sw_bus[int'(sw_sel) * 8 +: 8];
      h2[e]    = sw_bus[int'(sw_sel[0]) * 8 +: 8];
      hv[e]    = in_valid;
      tick();
      for (int s = 1; s <= 4; s++) begin
        if (e >= s - 1) begin
          e16 = h16[e-s+1];
          e2  = h2[e-s+1];
          ev  = hv[e-s+1];
        end else begin
          e16 = 8'h00;
          e2  = 8'h00;
          ev  = 1'b0;
        end
        n_checks++;
        if (sw16_out[s] !== e16 || sw16_v[s] !== ev) begin
          n_fail++;
          $display("[TB] FAIL sweep16 s=%0d e=%0d: got %h/%b expected %h/%b", s, e, sw16_out[s], sw16_v[s], e16, ev);
        end
        n_checks++;
        if (sw2_out[s] !== e2 || sw2_v[s] !== ev) begin
          n_fail++;
          $display("[TB] FAIL sweep2 s=%0d e=%0d: got %h/%b expected %h/%b", s, e, sw2_out[s], sw2_v[s], e2, ev);
        end
        n_checks++;
        if (sw16_err[s] !== 1'b0 || sw2_err[s] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL sweep_sel_err s=%0d e=%0d: got %b/%b expected 0/0", s, e, sw16_err[s], sw2_err[s]);
        end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bad_select();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
